// File: rtl/npc_pkg.sv
// Shared NPC core definitions: ALU operation encoding, RV32I opcodes and the
// FSM state type of the decode stage.
package npc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } idu_state_e;

  // 'alt' selects SUB/SRA; it only matters for funct3 000 and 101.
  function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
    unique case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate extraction for the decode stage: sign-extended I- and J-type
// immediates and the U-type upper immediate.
module idu_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u = XLEN'({inst[31:12], 12'b0});
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/idu_stage.sv
// RV32I decode stage between IFU and EXU: decodes, reads and forwards operands,
// registers one packet for EXU and halts after EBREAK.
module idu_stage
  import npc_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NR_REGS = 32,
  localparam int RA_W    = $clog2(NR_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [RA_W-1:0] out_rd,
  output logic            out_rf_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            out_jump,
  output logic [XLEN-1:0] out_jtarget,
  output logic            out_illegal,
  output logic            stop
);

  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [RA_W-1:0] rd;
    logic            rf_wen;
    logic            jump;
    logic [XLEN-1:0] jtarget;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } pkt_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx, rs1_idx, rs2_idx;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign funct7  = in_inst[31:25];
  assign rd_idx  = in_inst[11:7];
  assign rs1_idx = in_inst[19:15];
  assign rs2_idx = in_inst[24:20];

  assign rs1_addr = rs1_idx[RA_W-1:0];
  assign rs2_addr = rs2_idx[RA_W-1:0];

  logic [XLEN-1:0] imm_i, imm_u, imm_j;

  idu_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (in_inst),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // A write-back landing this cycle has not reached the regfile yet; x0 never forwards.
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1_addr == '0) ? '0 :
                   (wb_wen && wb_waddr == rs1_addr) ? wb_wdata : rs1_data;
  assign rs2_val = (rs2_addr == '0) ? '0 :
                   (wb_wen && wb_waddr == rs2_addr) ? wb_wdata : rs2_data;

  pkt_t pkt_d, pkt_q;
  logic use_rd, use_rs1, use_rs2, is_ebreak, illegal;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pkt_d     = '0;
    pkt_d.op  = ALU_ADD;
    pkt_d.pc  = in_pc;
    pkt_d.rd  = rd_idx[RA_W-1:0];
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    is_ebreak = 1'b0;
    illegal   = 1'b0;

    unique case (opcode)
      OPC_OPIMM: begin
        use_rd     = 1'b1;
        use_rs1    = 1'b1;
        pkt_d.src1 = rs1_val;
        pkt_d.src2 = imm_i;
        pkt_d.op   = funct3_op(funct3, (funct3 == 3'b101) && in_inst[30]);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          pkt_d.src2 = XLEN'(in_inst[24:20]);
          illegal    = !(funct7 == 7'b0000000 ||
                         (funct3 == 3'b101 && funct7 == 7'b0100000));
        end
      end
      OPC_OP: begin
        use_rd     = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        pkt_d.src1 = rs1_val;
        pkt_d.src2 = rs2_val;
        if (funct7 == 7'b0000000)
          pkt_d.op = funct3_op(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          pkt_d.op = funct3_op(funct3, 1'b1);
        else
          illegal = 1'b1;
      end
      OPC_LUI: begin
        use_rd     = 1'b1;
        pkt_d.src2 = imm_u;
      end
      OPC_AUIPC: begin
        use_rd     = 1'b1;
        pkt_d.src1 = in_pc;
        pkt_d.src2 = imm_u;
      end
      OPC_JAL: begin
        use_rd        = 1'b1;
        pkt_d.src1    = in_pc;
        pkt_d.src2    = XLEN'(4);
        pkt_d.jump    = 1'b1;
        pkt_d.jtarget = in_pc + imm_j;
      end
      OPC_JALR: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        pkt_d.src1    = in_pc;
        pkt_d.src2    = XLEN'(4);
        pkt_d.jump    = 1'b1;
        pkt_d.jtarget = (rs1_val + imm_i) & ~XLEN'(1);
        illegal       = (funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        is_ebreak = (in_inst == INST_EBREAK);
        illegal   = !is_ebreak;
      end
      default: illegal = 1'b1;
    endcase

    // RV32E has no x16..x31; any referenced register above x15 is out of range.
    if (NR_REGS == 16 &&
        ((use_rd && rd_idx[4]) || (use_rs1 && rs1_idx[4]) || (use_rs2 && rs2_idx[4])))
      illegal = 1'b1;

    if (illegal) begin
      pkt_d.op      = ALU_ADD;
      pkt_d.src1    = '0;
      pkt_d.src2    = '0;
      pkt_d.jump    = 1'b0;
      pkt_d.jtarget = '0;
    end
    pkt_d.illegal = illegal;
    pkt_d.rf_wen  = use_rd && !illegal && (rd_idx != 5'd0);
  end

  idu_state_e state_q, state_d;
  logic       valid_q, xfer;

  assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && xfer && is_ebreak)
      state_d = ST_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // NOTE: the packet payload is reset as well, because EXU-visible outputs
  // must read zero while in reset, not just out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      pkt_q   <= pkt_d;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = pkt_q.op;
  assign out_src1    = pkt_q.src1;
  assign out_src2    = pkt_q.src2;
  assign out_rd      = pkt_q.rd;
  assign out_rf_wen  = pkt_q.rf_wen;
  assign out_pc      = pkt_q.pc;
  assign out_jump    = pkt_q.jump;
  assign out_jtarget = pkt_q.jtarget;
  assign out_illegal = pkt_q.illegal;
  assign stop        = (state_q == ST_HALT);

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Pipelined, parametrised decode stage for the NPC core. Sits between IFU and EXU, both sides on valid/ready handshakes.
- Decodes the RV32I integer subset (OP-IMM, OP, LUI, AUIPC, JAL, JALR, EBREAK), reads operands from an external regfile and forwards same-cycle write-back data.
- Registers one decoded packet for EXU.
- Latches a sticky halt on EBREAK; flags illegal encodings instead of silently dropping them.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NR_REGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E).
- RA_W, $clog2(NR_REGS), regfile address width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IFU instruction valid
- in_ready  out  1  IDU can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rs1_addr  out  RA_W  regfile read address 1 (combinational from in_inst)
- rs2_addr  out  RA_W  regfile read address 2
- rs1_data  in  XLEN  regfile read data 1 (combinational)
- rs2_data  in  XLEN  regfile read data 2
- wb_wen  in  1  write-back enable this cycle
- wb_waddr  in  RA_W  write-back address
- wb_wdata  in  XLEN  write-back data
- out_valid  out  1  decoded packet valid
- out_ready  in  1  EXU accepts packet
- out_alu_op  out  4  alu_op_e from npc_pkg
- out_src1  out  XLEN  ALU operand 1
- out_src2  out  XLEN  ALU operand 2
- out_rd  out  RA_W  destination register
- out_rf_wen  out  1  write rd (forced 0 when rd==0)
- out_pc  out  XLEN  PC of packet
- out_jump  out  1  JAL/JALR; EXU writes pc+4 to rd and redirects
- out_jtarget  out  XLEN  JAL: pc+imm; JALR: (rs1+imm)&~1
- out_illegal  out  1  unsupported or out-of-range encoding
- stop  out  1  sticky halt after EBREAK

Behaviour:
- Reset (rst=0, async): all out_* and stop are 0; state=RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready). Transfer on in_valid && in_ready.
- Latency: 1 cycle; packet visible the cycle after transfer.
- Output register:
  - On transfer: load the new packet and set out_valid=1.
  - Else if out_ready: clear out_valid.
  - Else: hold all outputs stable.
- Back-to-back transfers at full throughput when out_ready=1.
- Operand forwarding: if wb_wen && wb_waddr==rsN && rsN!=0, use wb_wdata; else rsN_data. Register x0 always reads 0.
- Operand selection:
  - OP-IMM: src1=rs1, src2=sext(I-imm).
  - OP: src1=rs1, src2=rs2.
  - LUI: src1=0, src2=U-imm, op=ADD.
  - AUIPC: src1=pc, src2=U-imm, op=ADD.
  - JAL/JALR: src1=pc, src2=4, op=ADD.
- Shift immediates use inst[24:20]. SRAI is selected by inst[30]; SUB/SRA in OP are selected by funct7=0100000.
- Illegal conditions:
  - unknown opcode or funct;
  - slli/srli/srai with a bad funct7;
  - NR_REGS==16 and any used register index has bit 4 set.
- Illegal packet: out_illegal=1, out_rf_wen=0, out_jump=0, op=ADD.
- FSM, RUN -> HALT: on transfer of EBREAK (0x00100073). That packet is emitted with rf_wen=0 and stop=1 in the same cycle as its out_valid.
- FSM, HALT: in_ready=0 forever, stop held at 1, out_valid drains normally. Only reset exits HALT.
- ECALL and other SYSTEM encodings are illegal.
- Reset mid-stream: any pending packet is discarded immediately; no partial state survives.

Decomposition:
- npc_pkg holds:
  - alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - opcode constants (OPC_OPIMM=0010011, OPC_OP=0110011, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM);
  - INST_EBREAK.
- One sub-module, idu_imm_gen: combinational I/U/J immediate extraction and sign extension.
- Decode logic and the pipeline register stay in idu_stage.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x80000000, out_ready=1 -> next cycle out_valid=1, op=ADD, src1=0, src2=5, rd=1, rf_wen=1, illegal=0.
- add x3,x1,x2 with rs1_data=7, rs2_data=9, and wb_wen=1, wb_waddr=2, wb_wdata=100 in the same cycle -> src1=7, src2=100 (forwarded).
- out_ready=0 for 3 cycles with a packet held -> in_ready=0 and outputs unchanged. Release -> next queued instruction issues the following cycle; no loss or duplication.
- jalr x1,8(x5) with x5=0x80000011 -> jump=1, jtarget=0x80000018, src1=pc, src2=4.
- EBREAK, then further in_valid -> stop=1 with the packet, in_ready stays 0. Assert rst=0 mid-halt -> stop=0, out_valid=0 immediately.
- NR_REGS=16 build: add x17,x1,x2 -> illegal=1, rf_wen=0. Opcode 0x0000007F -> illegal=1.
